serv_ibus_rom: RTL and testbench

//  Wishbone-classic instruction-bus responder: the memory end of the fetch port driven by the

---
 rtl/serv_ibus_rom.sv | 157 +++++++++++++++
 tb/tb_serv_ibus_rom.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serv_ibus_rom.sv
// Wishbone-classic instruction ROM responder with programmable wait states and a side load port.
// Optional one-entry hit buffer enabled by defining SERV_IBUS_HITBUF_EN.
module serv_ibus_rom #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2,
   parameter string       MEMFILE = "",
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic [31:0]   i_wb_adr,
   input  logic          i_wb_cyc,
   output logic [31:0]   o_wb_rdt,
   output logic          o_wb_ack,
   output logic          o_wb_err,
   input  logic          i_ld_en,
   input  logic [AW-1:0] i_ld_adr,
   input  logic [31:0]   i_ld_dat
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          mis_q, mis_d;
   logic [31:0]   rdt_q, rdt_d;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] req_idx;
   logic          req_mis;
   logic [AW-1:0] rd_idx;
   logic          rd_mis;
   logic [31:0]   rd_word;
   logic          hit;
   logic          enter_resp;
   logic          unused_adr;

   assign req_idx    = i_wb_adr[AW+1:2];
   assign req_mis    = |i_wb_adr[1:0];
   assign unused_adr = ^i_wb_adr[31:AW+2];

   // A response entered straight from idle uses the live address, otherwise the latched one.
   assign rd_idx     = (state_q == StIdle) ? req_idx : idx_q;
   assign rd_mis     = (state_q == StIdle) ? req_mis : mis_q;
   assign enter_resp = (state_d == StResp);

   always_ff @(posedge clk) begin
      if (i_ld_en) begin
         mem[i_ld_adr] <= i_ld_dat;
      end
   end

`ifdef SERV_IBUS_HITBUF_EN
   logic          hb_valid_q, hb_valid_d;
   logic [AW-1:0] hb_idx_q, hb_idx_d;
   logic [31:0]   hb_word_q, hb_word_d;

   assign hit     = (state_q == StIdle) && i_wb_cyc && !req_mis && hb_valid_q &&
                    (hb_idx_q == req_idx);
   assign rd_word = hit ? hb_word_q : mem[rd_idx];

   // A load to the index being captured wins, so the buffer never holds a stale word.
   always_comb begin
      hb_valid_d = hb_valid_q;
      hb_idx_d   = hb_idx_q;
      hb_word_d  = hb_word_q;
      if (i_ld_en && (i_ld_adr == hb_idx_q)) begin
         hb_valid_d = 1'b0;
      end
      if (enter_resp && !rd_mis) begin
         hb_idx_d   = rd_idx;
         hb_word_d  = rd_word;
         hb_valid_d = !(i_ld_en && (i_ld_adr == rd_idx));
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         hb_valid_q <= 1'b0;
         hb_idx_q   <= '0;
         hb_word_q  <= '0;
      end else begin
         hb_valid_q <= hb_valid_d;
         hb_idx_q   <= hb_idx_d;
         hb_word_q  <= hb_word_d;
      end
   end
`else
   assign hit     = 1'b0;
   assign rd_word = mem[rd_idx];
`endif

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         rdt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         rdt_q   <= rdt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      case (state_q)
         StIdle: begin
            if (i_wb_cyc) begin
               idx_d = req_idx;
               mis_d = req_mis;
               cnt_d = 4'(LATENCY - 1);
               if ((LATENCY == 1) || hit) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (!i_wb_cyc) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = StResp;
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdt_d = rdt_q;
      if (enter_resp && !rd_mis) begin
         rdt_d = rd_word;
      end
   end

   always_comb begin
      o_wb_ack = (state_q == StResp) && !mis_q;
      o_wb_err = (state_q == StResp) && mis_q;
      o_wb_rdt = rdt_q;
   end

endmodule

// File: tb/tb_serv_ibus_rom.sv
// Bench for serv_ibus_rom: vector table, hand-written corner sequences and random fetches
// checked against a word-array model of the store plus a last-ack hit-buffer model.
module tb_serv_ibus_rom;

   localparam int LAT  = 2;
   localparam int LAT3 = 3;
`ifdef SERV_IBUS_HITBUF_EN
   localparam bit HB = 1'b1;
`else
   localparam bit HB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr, adr3, rdt, rdt3, ld_dat;
   logic        cyc, cyc3, ack, ack3, err, err3, ld_en;
   logic [7:0]  ld_adr;

   logic [31:0] m [256];
   logic [31:0] m3 [16];
   logic [31:0] mrdt;
   bit          bv;
   logic [7:0]  bidx;
   bit          cyc_held;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] adr;
      bit          keep;
      logic [31:0] rdt;
   } vec_t;
   vec_t tbl [9];

   always #5 clk = ~clk;

   serv_ibus_rom #(.DEPTH(256), .LATENCY(LAT), .MEMFILE("")) u_dut (
      .clk      (clk),
      .i_rst_n  (rst_n),
      .i_wb_adr (adr),
      .i_wb_cyc (cyc),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_wb_err (err),
      .i_ld_en  (ld_en),
      .i_ld_adr (ld_adr),
      .i_ld_dat (ld_dat)
   );

   serv_ibus_rom #(.DEPTH(16), .LATENCY(LAT3), .MEMFILE("")) u_dut3 (
      .clk      (clk),
      .i_rst_n  (rst_n),
      .i_wb_adr (adr3),
      .i_wb_cyc (cyc3),
      .o_wb_rdt (rdt3),
      .o_wb_ack (ack3),
      .o_wb_err (err3),
      .i_ld_en  (ld_en),
      .i_ld_adr (ld_adr[3:0]),
      .i_ld_dat (ld_dat)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0] i, input logic [31:0] d);
      ld_en  = 1'b1;
      ld_adr = i;
      ld_dat = d;
      @(negedge clk);
      ld_en    = 1'b0;
      m[i]     = d;
      m3[i[3:0]] = d;
      if (bv && (bidx == i)) bv = 1'b0;
   endtask

   // Issue one fetch; latency counted in negedges from issue to the completion sample.
   task automatic fetch(input logic [31:0] a, input bit keep, input string name);
      int         n;
      int         exp_n;
      logic [7:0] i;
      bit         mis;
      i     = a[9:2];
      mis   = (a[1:0] != 2'b00);
      exp_n = ((HB && !mis && bv && (bidx == i)) ? 1 : LAT) + (cyc_held ? 1 : 0);
      cyc = 1'b1;
      adr = a;
      n   = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack || err) && (n < 40));
      chk({name, " latency"}, 32'(n), 32'(exp_n));
      chk({name, " ack"}, {31'b0, ack}, {31'b0, !mis});
      chk({name, " err"}, {31'b0, err}, {31'b0, mis});
      if (!mis) begin
         mrdt = m[i];
         bv   = 1'b1;
         bidx = i;
      end
      chk({name, " rdt"}, rdt, mrdt);
      if (keep) begin
         cyc_held = 1'b1;
      end else begin
         cyc      = 1'b0;
         cyc_held = 1'b0;
         @(negedge clk);
         chk({name, " one-cycle"}, {30'b0, ack, err}, 32'd0);
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{32'h0000_0010, 1'b0, 32'h0050_0093};
      tbl[1] = '{32'h0000_0012, 1'b0, 32'h0050_0093};
      tbl[2] = '{32'h0000_0014, 1'b0, 32'h1005_0505};
      tbl[3] = '{32'h0000_0400, 1'b0, 32'h1000_0000};
      tbl[4] = '{32'hFFFF_FC08, 1'b1, 32'h1002_0202};
      tbl[5] = '{32'h0000_03FC, 1'b1, 32'h10FF_FFFF};
      tbl[6] = '{32'h0000_03FD, 1'b0, 32'h10FF_FFFF};
      tbl[7] = '{32'h0000_0010, 1'b0, 32'h0050_0093};
      tbl[8] = '{32'h0000_0010, 1'b0, 32'h0050_0093};

      rst_n = 1'b0; cyc = 1'b0; adr = '0; cyc3 = 1'b0; adr3 = '0;
      ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
      mrdt = '0; bv = 1'b0; bidx = '0; cyc_held = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset ack/err", {30'b0, ack, err}, 32'd0);
      chk("reset rdt", rdt, 32'd0);
      chk("reset rdt3", rdt3, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) load(8'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0101);
      load(8'd4, 32'h0050_0093);

      for (int k = 0; k < 9; k++) begin
         fetch(tbl[k].adr, tbl[k].keep, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d table rdt", k), rdt, tbl[k].rdt);
      end

      // Abort during wait states on the LATENCY=3 instance, then a normal fetch.
      cyc3 = 1'b1; adr3 = 32'h10;
      @(negedge clk);
      cyc3 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("abort silent", {30'b0, ack3, err3}, 32'd0);
      end
      cyc3 = 1'b1; n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack3 || err3) && (n < 40));
      chk("after abort latency", 32'(n), 32'(LAT3));
      chk("after abort ack", {31'b0, ack3}, 32'd1);
      chk("after abort rdt", rdt3, m3[4]);
      cyc3 = 1'b0;
      @(negedge clk);
      chk("after abort one-cycle", {30'b0, ack3, err3}, 32'd0);

      // Reset one cycle before the ack is due.
      cyc = 1'b1; adr = 32'h18;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset mid-fetch ack/err", {30'b0, ack, err}, 32'd0);
      chk("reset mid-fetch rdt", rdt, 32'd0);
      cyc = 1'b0; rst_n = 1'b1; mrdt = '0; bv = 1'b0; cyc_held = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no ack after reset", {30'b0, ack, err}, 32'd0);
      end

      // Wrapped address read on the same edge as a load to that index returns the old word.
      cyc = 1'b1; adr = 32'h400;
      @(negedge clk);
      ld_en = 1'b1; ld_adr = 8'd0; ld_dat = 32'hDEAD_BEEF;
      @(negedge clk);
      ld_en = 1'b0;
      chk("rbw ack", {31'b0, ack}, 32'd1);
      chk("rbw old word", rdt, m[0]);
      mrdt = m[0]; m[0] = 32'hDEAD_BEEF; m3[0] = 32'hDEAD_BEEF; bv = 1'b0;
      cyc = 1'b0;
      @(negedge clk);
      chk("rbw one-cycle", {30'b0, ack, err}, 32'd0);
      fetch(32'h400, 1'b0, "rbw new word");

      fetch(32'h10, 1'b0, "hit first");
      fetch(32'h10, 1'b0, "hit second");
      load(8'd4, 32'h0BAD_F00D);
      fetch(32'h10, 1'b0, "hit after load");

      for (int k = 0; k < 120; k++) begin
         int          r;
         logic [31:0] a;
         logic [7:0]  i;
         r = int'($urandom_range(0, 9));
         if ((r < 2) && !cyc_held) begin
            load(8'($urandom_range(0, 255)), $urandom);
         end else begin
            i = ((r < 5) && bv) ? bidx : 8'($urandom_range(0, 255));
            a = $urandom;
            a[9:2] = i;
            a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fetch(a, (k < 119) && ($urandom_range(0, 3) == 0), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
